// File: rtl/nudt_pkg.sv
// Shared definitions for the NUDT 1K baseband: PIE decoder state encoding,
// interval width and default delimiter/data-0 limits.
package nudt_pkg;

  localparam int CNT_W = 8;

  localparam int DELIM_MIN_DEF = 20;
  localparam int DELIM_MAX_DEF = 30;
  localparam int D0_MIN_DEF    = 8;
  localparam int D0_MAX_DEF    = 50;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DELIM = 3'd1,
    DATA0 = 3'd2,
    RTCAL = 3'd3,
    FIRST = 3'd4,
    BITS  = 3'd5
  } pie_state_e;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    if (v == CNT_MAX) r = v;
    else              r = v + CNT_ONE;
    return r;
  endfunction

endpackage

// File: rtl/pie_edge_sync.sv
// Synchronizes the demodulated envelope and produces rise/fall pulses.
// PIE_DEGLITCH_EN adds a filter that needs 2 equal samples to change level.
module pie_edge_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;
  logic w_level;

  // Two-flop synchronizer; idles at carrier-on so reset makes no edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_async;
      r_sync2 <= r_sync1;
    end
  end

`ifdef PIE_DEGLITCH_EN
  logic r_dg0;
  logic r_filt;

  // Level follows the input only after two consecutive equal samples.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_dg0  <= 1'b1;
      r_filt <= 1'b1;
    end else begin
      r_dg0 <= r_sync2;
      if (r_sync2 == r_dg0) r_filt <= r_sync2;
      else                  r_filt <= r_filt;
    end
  end

  assign w_level = r_filt;
`else
  assign w_level = r_sync2;
`endif

  // Edge-detect register on the clean level.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_prev <= 1'b1;
    else       r_prev <= w_level;
  end

  assign o_level = w_level;
  assign o_rise  = w_level & ~r_prev;
  assign o_fall  = ~w_level & r_prev;

endmodule

// File: rtl/pie_decoder.sv
// Forward-link PIE decoder: delimiter, data-0, RTcal and TC measurement plus
// bit decode against RTcal/2. PIE_DEGLITCH_EN enables the input glitch filter.
module pie_decoder
  import nudt_pkg::*;
#(
  parameter int DELIM_MIN = DELIM_MIN_DEF,
  parameter int DELIM_MAX = DELIM_MAX_DEF,
  parameter int D0_MIN    = D0_MIN_DEF,
  parameter int D0_MAX    = D0_MAX_DEF
) (
  input  logic             clk_1_92m,
  input  logic             rst,
  input  logic             demod_in,
  output logic [CNT_W-1:0] TC_val,
  output logic             tc_vld,
  output logic             frame_start,
  output logic             bit_vld,
  output logic             bit_data,
  output logic             frame_end,
  output logic             frame_err,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             rx_busy
);

  localparam logic [CNT_W-1:0] L_DELIM_MIN = CNT_W'(DELIM_MIN);
  localparam logic [CNT_W-1:0] L_DELIM_MAX = CNT_W'(DELIM_MAX);
  localparam logic [CNT_W-1:0] L_D0_MIN    = CNT_W'(D0_MIN);
  localparam logic [CNT_W-1:0] L_D0_MAX    = CNT_W'(D0_MAX);

  logic w_level;
  logic w_rise;
  logic w_fall;

  pie_state_e       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [CNT_W-1:0] r_d0, w_d0_nxt;
  logic [CNT_W-1:0] r_rtcal, w_rtcal_nxt;
  logic [CNT_W-1:0] r_pivot, w_pivot_nxt;
  logic [CNT_W-1:0] r_tc_val, w_tc_val_nxt;
  logic [CNT_W-1:0] r_bit_cnt, w_bit_cnt_nxt;
  logic             w_tc_load;
  logic             r_tc_pend;
  logic             r_tc_vld;
  logic             r_frame_start, w_frame_start_nxt;
  logic             r_bit_vld, w_bit_vld_nxt;
  logic             r_bit_data, w_bit_data_nxt;
  logic             r_frame_end, w_frame_end_nxt;
  logic             r_frame_err, w_frame_err_nxt;
  logic             r_rx_busy;
  logic             w_abort;
  logic             w_timeout;

  pie_edge_sync u_edge (
    .i_clk   (clk_1_92m),
    .i_rst   (rst),
    .i_async (demod_in),
    .o_level (w_level),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

  assign w_abort   = (r_state != IDLE) && (r_cnt == CNT_MAX);
  // 9-bit compare so that 2*rtcal never wraps.
  assign w_timeout = ({1'b0, r_cnt} >= {r_rtcal, 1'b0});

  // Next-state and datapath decisions; every rise restarts the interval.
  always_comb begin
    w_state_nxt       = r_state;
    w_cnt_nxt         = cnt_sat_inc(r_cnt);
    w_d0_nxt          = r_d0;
    w_rtcal_nxt       = r_rtcal;
    w_pivot_nxt       = r_pivot;
    w_tc_val_nxt      = r_tc_val;
    w_tc_load         = 1'b0;
    w_bit_cnt_nxt     = r_bit_cnt;
    w_frame_start_nxt = 1'b0;
    w_bit_vld_nxt     = 1'b0;
    w_bit_data_nxt    = r_bit_data;
    w_frame_end_nxt   = 1'b0;
    w_frame_err_nxt   = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_fall) begin
          w_state_nxt = DELIM;
          w_cnt_nxt   = CNT_ONE;
        end else begin
          w_cnt_nxt = '0;
        end
      end
      DELIM: begin
        if (w_rise) begin
          if (r_cnt >= L_DELIM_MIN && r_cnt <= L_DELIM_MAX) begin
            w_state_nxt       = DATA0;
            w_cnt_nxt         = CNT_ONE;
            w_frame_start_nxt = 1'b1;
            w_bit_cnt_nxt     = '0;
          end else begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
          end
        end else if (r_cnt > L_DELIM_MAX) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else if (w_abort) begin
          w_state_nxt     = IDLE;
          w_cnt_nxt       = '0;
          w_frame_err_nxt = 1'b1;
        end else begin
          w_state_nxt = DELIM;
        end
      end
      DATA0: begin
        if (w_rise && r_cnt >= L_D0_MIN && r_cnt <= L_D0_MAX) begin
          w_state_nxt = RTCAL;
          w_cnt_nxt   = CNT_ONE;
          w_d0_nxt    = r_cnt;
        end else if (w_rise || w_abort) begin
          w_state_nxt     = IDLE;
          w_cnt_nxt       = '0;
          w_frame_err_nxt = 1'b1;
        end else begin
          w_state_nxt = DATA0;
        end
      end
      RTCAL: begin
        if (w_rise && r_cnt > r_d0) begin
          w_state_nxt = FIRST;
          w_cnt_nxt   = CNT_ONE;
          w_rtcal_nxt = r_cnt;
          w_pivot_nxt = {1'b0, r_cnt[CNT_W-1:1]};
        end else if (w_rise || w_abort) begin
          w_state_nxt     = IDLE;
          w_cnt_nxt       = '0;
          w_frame_err_nxt = 1'b1;
        end else begin
          w_state_nxt = RTCAL;
        end
      end
      FIRST: begin
        if (w_rise) begin
          w_state_nxt = BITS;
          w_cnt_nxt   = CNT_ONE;
          if (r_cnt > r_rtcal) begin
            w_tc_val_nxt = r_cnt;
            w_tc_load    = 1'b1;
          end else begin
            w_bit_vld_nxt  = 1'b1;
            w_bit_data_nxt = (r_cnt >= r_pivot);
            w_bit_cnt_nxt  = cnt_sat_inc(r_bit_cnt);
          end
        end else if (w_abort) begin
          w_state_nxt     = IDLE;
          w_cnt_nxt       = '0;
          w_frame_err_nxt = 1'b1;
        end else begin
          w_state_nxt = FIRST;
        end
      end
      BITS: begin
        if (w_rise) begin
          w_cnt_nxt      = CNT_ONE;
          w_bit_vld_nxt  = 1'b1;
          w_bit_data_nxt = (r_cnt >= r_pivot);
          w_bit_cnt_nxt  = cnt_sat_inc(r_bit_cnt);
        end else if (w_abort || w_timeout) begin
          w_state_nxt     = IDLE;
          w_cnt_nxt       = '0;
          w_frame_end_nxt = w_level & ~w_abort;
          w_frame_err_nxt = ~w_level | w_abort;
        end else begin
          w_state_nxt = BITS;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // State, measurements and registered output pulses.
  always_ff @(posedge clk_1_92m) begin
    if (rst) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_d0          <= '0;
      r_rtcal       <= '0;
      r_pivot       <= '0;
      r_tc_val      <= '0;
      r_tc_pend     <= 1'b0;
      r_tc_vld      <= 1'b0;
      r_bit_cnt     <= '0;
      r_frame_start <= 1'b0;
      r_bit_vld     <= 1'b0;
      r_bit_data    <= 1'b0;
      r_frame_end   <= 1'b0;
      r_frame_err   <= 1'b0;
      r_rx_busy     <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_d0          <= w_d0_nxt;
      r_rtcal       <= w_rtcal_nxt;
      r_pivot       <= w_pivot_nxt;
      r_tc_val      <= w_tc_val_nxt;
      r_tc_pend     <= w_tc_load;
      r_tc_vld      <= r_tc_pend;
      r_bit_cnt     <= w_bit_cnt_nxt;
      r_frame_start <= w_frame_start_nxt;
      r_bit_vld     <= w_bit_vld_nxt;
      r_bit_data    <= w_bit_data_nxt;
      r_frame_end   <= w_frame_end_nxt;
      r_frame_err   <= w_frame_err_nxt;
      r_rx_busy     <= (w_state_nxt != IDLE);
    end
  end

  assign TC_val      = r_tc_val;
  assign tc_vld      = r_tc_vld;
  assign frame_start = r_frame_start;
  assign bit_vld     = r_bit_vld;
  assign bit_data    = r_bit_data;
  assign frame_end   = r_frame_end;
  assign frame_err   = r_frame_err;
  assign bit_cnt     = r_bit_cnt;
  assign rx_busy     = r_rx_busy;

endmodule

// File: tb/tb_pie_decoder.sv
// Directed bench for pie_decoder: expected events are queued as PIE symbols
// are driven and checked in order as the decoder pulses its outputs.
module tb_pie_decoder;

`ifdef PIE_DEGLITCH_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 3;
`endif
  localparam int PW = 4;

  localparam int K_START = 0;
  localparam int K_TC    = 1;
  localparam int K_BIT   = 2;
  localparam int K_END   = 3;
  localparam int K_ERR   = 4;

  typedef struct {
    int kind;
    int val;
    int cyc;
  } ev_t;

  logic       clk_1_92m;
  logic       rst;
  logic       demod_in;
  logic [7:0] TC_val;
  logic       tc_vld;
  logic       frame_start;
  logic       bit_vld;
  logic       bit_data;
  logic       frame_end;
  logic       frame_err;
  logic [7:0] bit_cnt;
  logic       rx_busy;

  int   checks    = 0;
  int   failures  = 0;
  int   cyc       = 0;
  int   last_rise = 0;
  int   tc_chg    = -100;
  logic [7:0] tc_prev = 8'd0;
  ev_t  q[$];

  pie_decoder dut (
    .clk_1_92m   (clk_1_92m),
    .rst         (rst),
    .demod_in    (demod_in),
    .TC_val      (TC_val),
    .tc_vld      (tc_vld),
    .frame_start (frame_start),
    .bit_vld     (bit_vld),
    .bit_data    (bit_data),
    .frame_end   (frame_end),
    .frame_err   (frame_err),
    .bit_cnt     (bit_cnt),
    .rx_busy     (rx_busy)
  );

  initial begin
    clk_1_92m = 1'b0;
    forever #5 clk_1_92m = ~clk_1_92m;
  end

  always @(posedge clk_1_92m) cyc <= cyc + 1;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_ev(input string tag, input int kind, input int val);
    ev_t e;
    if (q.size() == 0) begin
      e.kind = -1;
      e.val  = -1;
      e.cyc  = -1;
    end else begin
      e = q.pop_front();
    end
    chk({tag, "_kind_val"}, kind * 256 + val, e.kind * 256 + e.val);
    if (e.cyc >= 0) chk({tag, "_cycle"}, cyc, e.cyc);
  endtask

  task automatic push(input int kind, input int val, input int at_cyc);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    e.cyc  = at_cyc;
    q.push_back(e);
  endtask

  // Output monitor: every pulse must match the head of the expectation queue.
  always @(negedge clk_1_92m) begin
    if (!rst) begin
      if (frame_start) chk_ev("frame_start", K_START, 0);
      if (tc_vld) begin
        chk_ev("tc_vld", K_TC, int'(TC_val));
        chk("tc_vld_after_load", cyc, tc_chg + 1);
      end
      if (bit_vld)   chk_ev("bit_vld", K_BIT, int'(bit_data));
      if (frame_end) chk_ev("frame_end", K_END, int'(bit_cnt));
      if (frame_err) chk_ev("frame_err", K_ERR, 0);
    end
    if (TC_val !== tc_prev) tc_chg = cyc;
    tc_prev = TC_val;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk_1_92m);
    #1;
  endtask

  task automatic delim(input int d);
    demod_in = 1'b0;
    wait_cyc(d);
    demod_in = 1'b1;
    last_rise = cyc;
  endtask

  task automatic sym(input int n);
    wait_cyc(n - PW);
    demod_in = 1'b0;
    wait_cyc(PW);
    demod_in = 1'b1;
    last_rise = cyc;
  endtask

  task automatic preamble;
    wait_cyc(10);
    delim(24);
    push(K_START, 0, -1);
    sym(12);
    sym(30);
  endtask

  initial begin
    rst      = 1'b1;
    demod_in = 1'b1;
    wait_cyc(5);
    chk("reset_tc_val", int'(TC_val), 0);
    chk("reset_pulses", int'({tc_vld, frame_start, bit_vld, bit_data, frame_end, frame_err}), 0);
    chk("reset_bit_cnt", int'(bit_cnt), 0);
    chk("reset_rx_busy", int'(rx_busy), 0);
    rst = 1'b0;

    // Full frame with TC then bits 0,1,0.
    preamble();
    sym(40); push(K_TC, 40, -1);
    sym(12); push(K_BIT, 0, -1);
    sym(24); push(K_BIT, 1, -1);
    sym(12); push(K_BIT, 0, -1);
    push(K_END, 3, last_rise + LAT + 60);
    wait_cyc(80);
    chk("a_rx_busy_idle", int'(rx_busy), 0);
    chk("a_tc_val", int'(TC_val), 40);
    chk("a_bit_cnt", int'(bit_cnt), 3);
    chk("a_queue_drained", q.size(), 0);

    // No TC: first symbol decodes as data; 15 equals pivot and reads as 1.
    preamble();
    sym(12); push(K_BIT, 0, -1);
    sym(24); push(K_BIT, 1, -1);
    sym(15); push(K_BIT, 1, -1);
    push(K_END, 3, last_rise + LAT + 60);
    wait_cyc(80);
    chk("b_tc_val_held", int'(TC_val), 40);
    chk("b_bit_cnt", int'(bit_cnt), 3);
    chk("b_queue_drained", q.size(), 0);

    // Delimiter too short.
    demod_in = 1'b0;
    wait_cyc(10);
    chk("d16_busy_in_delim", int'(rx_busy), 1);
    wait_cyc(6);
    demod_in = 1'b1;
    wait_cyc(10);
    chk("d16_busy_dropped", int'(rx_busy), 0);

    // Delimiter too long: abandoned while the line is still low.
    demod_in = 1'b0;
    wait_cyc(38);
    chk("d40_busy_dropped_low", int'(rx_busy), 0);
    wait_cyc(2);
    demod_in = 1'b1;
    wait_cyc(20);
    chk("d40_busy_idle", int'(rx_busy), 0);

    // Line stuck low in BITS: error at cnt = 2*rtcal.
    preamble();
    sym(12); push(K_BIT, 0, -1);
    push(K_ERR, 0, last_rise + LAT + 60);
    wait_cyc(4);
    demod_in = 1'b0;
    wait_cyc(70);
    demod_in = 1'b1;
    wait_cyc(20);
    chk("low_busy_idle", int'(rx_busy), 0);
    chk("low_bit_cnt", int'(bit_cnt), 1);
    chk("low_queue_drained", q.size(), 0);

    // RTcal not longer than data-0.
    wait_cyc(10);
    delim(24);
    push(K_START, 0, -1);
    sym(12);
    sym(10);
    push(K_ERR, 0, last_rise + LAT);
    wait_cyc(20);
    chk("rtcal_busy_idle", int'(rx_busy), 0);
    chk("rtcal_queue_drained", q.size(), 0);

    // One-cycle low glitch while idle.
    wait_cyc(10);
    demod_in = 1'b0;
    wait_cyc(1);
    demod_in = 1'b1;
    wait_cyc(2);
`ifdef PIE_DEGLITCH_EN
    chk("glitch_filtered", int'(rx_busy), 0);
`else
    chk("glitch_seen", int'(rx_busy), 1);
`endif
    wait_cyc(10);
    chk("glitch_busy_idle", int'(rx_busy), 0);

    // Reset in the middle of BITS.
    preamble();
    sym(24); push(K_BIT, 1, -1);
    wait_cyc(10);
    chk("mid_busy_before_rst", int'(rx_busy), 1);
    rst = 1'b1;
    wait_cyc(1);
    chk("rst_tc_val", int'(TC_val), 0);
    chk("rst_pulses", int'({tc_vld, frame_start, bit_vld, bit_data, frame_end, frame_err}), 0);
    chk("rst_bit_cnt", int'(bit_cnt), 0);
    chk("rst_rx_busy", int'(rx_busy), 0);
    rst = 1'b0;
    wait_cyc(80);
    chk("rst_no_events", int'({frame_end, frame_err, rx_busy}), 0);
    chk("final_queue_drained", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
